// File: rtl/uart_sink_pkg.sv
// Shared types and constants for the bench-side UART receiver sink.
package uart_sink_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_sink_state_e;

endpackage

// File: rtl/uart_sink_fifo.sv
// First-word-fall-through byte FIFO; a pop while full frees the slot for a same-cycle push.
module uart_sink_fifo
  import uart_sink_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB tells a wrapped (full) writer from an equal (empty) one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is masked to zero when empty so the consumer sees a defined byte.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_sink.sv
// 8N1 serial receiver: synchronizer, bit-timing divider and framing FSM feeding a byte FIFO.
module uart_rx_sink
  import uart_sink_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        framing_err,
  output logic        overrun,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam int          IDX_W     = $clog2(UART_DATA_BITS);
  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic                      sync1;
  logic                      rxs;
  uart_sink_state_e          state;
  uart_sink_state_e          state_next;
  logic [15:0]               div_cnt;
  logic [15:0]               div_next;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          bit_next;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic                      push_pend;
  logic                      push_next;
  logic                      ferr_next;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      accepted;

  // Synchronizer idles at 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      push_pend   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_next;
      div_cnt     <= div_next;
      bit_idx     <= bit_next;
      shift_reg   <= shift_next;
      push_pend   <= push_next;
      framing_err <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    push_next  = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          div_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (div_cnt != 16'd0) begin
          div_next = div_cnt - 16'd1;
        end else if (rxs) begin
          state_next = IDLE;
        end else begin
          div_next   = FULL_LOAD;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (div_cnt != 16'd0) begin
          div_next = div_cnt - 16'd1;
        end else begin
          shift_next[bit_idx] = rxs;
          div_next            = FULL_LOAD;
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (div_cnt != 16'd0) begin
          div_next = div_cnt - 16'd1;
        end else if (rxs) begin
          push_next  = 1'b1;
          state_next = IDLE;
        end else begin
          ferr_next  = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO is never empty, so rx_ready alone means the head leaves this cycle.
  assign overrun  = push_pend && fifo_full && !rx_ready;
  assign accepted = push_pend && !overrun;
  assign busy     = (state != IDLE);
  assign rx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_count <= '0;
    end else if (accepted) begin
      byte_count <= byte_count + 16'd1;
    end
  end

  uart_sink_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_pend),
    .push_data (shift_reg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
